// File: rtl/seg_pkg.sv
// Shared display definitions: blank pattern, hex-to-segment table and scan FSM encoding.
package seg_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Active-low g..a patterns; entry 0 is the least significant element.
   localparam logic [15:0][6:0] SEG_HEX_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment (g..a) decoder.
module seg7_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_c
);

   assign seg_c = SEG_HEX_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with double-buffered display data,
// per-slot anti-ghost blanking and per-digit blink.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 8,
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLANK_CYCLES = 16,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blink_en,
   input  logic                    load,
   output logic                    pending,
   output logic                    frame_start,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic [7:0]              seg
);

   localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned SLOT_W  = $clog2(SCAN_DIV);
   localparam int unsigned FRAME_W = $clog2(BLINK_FRAMES + 1);
   localparam int unsigned DIG_W   = 4 * NUM_DIGITS;

   localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0]  BLANK_END  = SLOT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [FRAME_W-1:0] FRAME_WRAP = FRAME_W'(BLINK_FRAMES);

   scan_state_e            state_q, state_d;
   logic [SLOT_W-1:0]      slot_cnt_q, slot_cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [FRAME_W-1:0]     frame_cnt_q, frame_cnt_d;
   logic                   blink_phase_q, blink_phase_d;
   logic                   frame_start_q, frame_start_d;
   logic                   pending_q, pending_d;
   logic [DIG_W-1:0]       stg_dig_q, stg_dig_d;
   logic [NUM_DIGITS-1:0]  stg_dp_q, stg_dp_d;
   logic [NUM_DIGITS-1:0]  stg_blink_q, stg_blink_d;
   logic [DIG_W-1:0]       act_dig_q, act_dig_d;
   logic [NUM_DIGITS-1:0]  act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0]  act_blink_q, act_blink_d;
   logic [NUM_DIGITS-1:0]  dig_sel_q, dig_sel_d;
   logic [7:0]             seg_q, seg_d;

   logic                   frame_end;
   logic [FRAME_W-1:0]     frame_inc;
   logic [3:0]             nib_sel;
   logic                   dp_sel;
   logic                   blink_sel;
   logic [6:0]             seg_hex_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_BLANK;
         slot_cnt_q    <= '0;
         idx_q         <= '0;
         frame_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         frame_start_q <= 1'b0;
         pending_q     <= 1'b0;
         stg_dig_q     <= '0;
         stg_dp_q      <= '0;
         stg_blink_q   <= '0;
         act_dig_q     <= '0;
         act_dp_q      <= '0;
         act_blink_q   <= '0;
         dig_sel_q     <= '1;
         seg_q         <= SEG_BLANK;
      end else begin
         state_q       <= state_d;
         slot_cnt_q    <= slot_cnt_d;
         idx_q         <= idx_d;
         frame_cnt_q   <= frame_cnt_d;
         blink_phase_q <= blink_phase_d;
         frame_start_q <= frame_start_d;
         pending_q     <= pending_d;
         stg_dig_q     <= stg_dig_d;
         stg_dp_q      <= stg_dp_d;
         stg_blink_q   <= stg_blink_d;
         act_dig_q     <= act_dig_d;
         act_dp_q      <= act_dp_d;
         act_blink_q   <= act_blink_d;
         dig_sel_q     <= dig_sel_d;
         seg_q         <= seg_d;
      end
   end

   // Scan counters, blink timing, staging/active buffering and BLANK/SHOW state.
   always_comb begin
      slot_cnt_d    = slot_cnt_q + SLOT_W'(1);
      idx_d         = idx_q;
      frame_cnt_d   = frame_cnt_q;
      blink_phase_d = blink_phase_q;
      pending_d     = pending_q;
      stg_dig_d     = stg_dig_q;
      stg_dp_d      = stg_dp_q;
      stg_blink_d   = stg_blink_q;
      act_dig_d     = act_dig_q;
      act_dp_d      = act_dp_q;
      act_blink_d   = act_blink_q;
      state_d       = state_q;
      frame_inc     = frame_cnt_q + FRAME_W'(1);
      frame_end     = (slot_cnt_q == LAST_SLOT) && (idx_q == LAST_IDX);
      frame_start_d = frame_end;

      if (slot_cnt_q == LAST_SLOT) begin
         slot_cnt_d = '0;
         idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end

      if (frame_end) begin
         if (frame_inc == FRAME_WRAP) begin
            frame_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            frame_cnt_d = frame_inc;
         end
      end

      // A load on the frame edge bypasses staging so it is never left pending.
      if (load) begin
         stg_dig_d   = digits_in;
         stg_dp_d    = dp_in;
         stg_blink_d = blink_en;
      end
      if (frame_end && load) begin
         act_dig_d   = digits_in;
         act_dp_d    = dp_in;
         act_blink_d = blink_en;
         pending_d   = 1'b0;
      end else if (frame_end && pending_q) begin
         act_dig_d   = stg_dig_q;
         act_dp_d    = stg_dp_q;
         act_blink_d = stg_blink_q;
         pending_d   = 1'b0;
      end else if (load) begin
         pending_d   = 1'b1;
      end

      case (state_q)
         ST_BLANK: if (slot_cnt_d == BLANK_END) state_d = ST_SHOW;
         ST_SHOW:  if (slot_cnt_d == '0)        state_d = ST_BLANK;
         default:  state_d = ST_BLANK;
      endcase
   end

   // Select the next cycle's digit data so the output flops line up with the counters.
   always_comb begin
      nib_sel   = 4'h0;
      dp_sel    = 1'b0;
      blink_sel = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_d == IDX_W'(i)) begin
            nib_sel   = act_dig_d[4*i +: 4];
            dp_sel    = act_dp_d[i];
            blink_sel = act_blink_d[i];
         end
      end
   end

   seg7_decode u_decode (
      .nibble (nib_sel),
      .seg_c  (seg_hex_c)
   );

   always_comb begin
      dig_sel_d = '1;
      seg_d     = SEG_BLANK;
      if (state_d == ST_SHOW) begin
         dig_sel_d = ~(NUM_DIGITS'(1) << idx_d);
         if (!(blink_phase_d && blink_sel)) begin
            seg_d = {~dp_sel, seg_hex_c};
         end
      end
   end

   assign pending     = pending_q;
   assign frame_start = frame_start_q;
   assign dig_sel     = dig_sel_q;
   assign seg         = seg_q;

endmodule
